alu_issue_writeback: RTL and testbench
======================================

Name: alu_issue_writeback

Overview:
- Operand-issue and result-writeback stage wrapped around the ALU. Holds an 8 x 32-bit register file.
- Accepts one instruction at a time over a valid/ready handshake. Drives the ALU's A, B, FunSel and WF inputs, then writes the ALU result back into the destination register.
- Consumes the ALU's FlagsOut {Z,C,N,O} to support conditional execution.
- Sits between the instruction source (sequencer/testbench) and the ALU.

Parameters:
- NREG, 8, number of general registers (index width 3; fixed, not intended for override)
- DW, 32, data width (must match the ALU)

Ports:
- Clock  in  1  system clock, all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset
- InValid  in  1  instruction present
- InReady  out  1  stage can accept an instruction this cycle
- InFunSel  in  5  ALU function select, passed unmodified to the ALU
- InSrcA  in  3  register index for ALU operand A
- InSrcB  in  3  register index for ALU operand B
- InDst  in  3  destination register index
- InS  in  1  update ALU flags when the instruction executes
- InCond  in  2  execution condition: 00 always, 01 Z==1, 10 Z==0, 11 C==1
- InLoadImm  in  1  write InImm to Dst; the ALU is not used
- InImm  in  32  immediate value
- A  out  32  ALU operand A (registered)
- B  out  32  ALU operand B (registered)
- FunSel  out  5  ALU function select (registered)
- WF  out  1  ALU flag-write enable (registered)
- ALUOut  in  32  ALU result (combinational from the ALU)
- FlagsIn  in  4  ALU FlagsOut {Z,C,N,O}
- Done  out  1  one-cycle pulse: instruction retired
- Skipped  out  1  qualifies Done: condition false, nothing written
- DbgSel  in  3  debug read index
- DbgData  out  32  combinational read of register DbgSel

Behaviour:
- Reset (synchronous, overrides everything, including mid-ISSUE):
  - All registers 0; state IDLE.
  - A, B = 0; FunSel = 0; WF = 0; Done = 0; Skipped = 0; InReady = 1.
  - An in-flight write is discarded.
- States: IDLE, ISSUE. InReady = 1 only in IDLE.
- Accept = InValid & InReady, sampled at the rising edge.
- Condition is evaluated at the accept edge from FlagsIn: cond_ok = (00) | (01 & Z) | (10 & ~Z) | (11 & C). Flags cannot change between accept and ISSUE, because WF is 0 in IDLE.
- Accept with InLoadImm = 1:
  - If cond_ok, R[InDst] <= InImm at the accept edge.
  - Stay in IDLE; WF stays 0.
  - Next cycle: Done = 1, Skipped = ~cond_ok.
- Accept with InLoadImm = 0, cond_ok = 1:
  - Registered at the accept edge: A <= R[InSrcA], B <= R[InSrcB], FunSel <= InFunSel, WF <= InS. Dst is latched.
  - Go to ISSUE.
- Accept with InLoadImm = 0, cond_ok = 0:
  - No ISSUE; A, B, FunSel and WF are unchanged except WF <= 0.
  - Next cycle: Done = 1, Skipped = 1.
- ISSUE lasts exactly one cycle:
  - At its closing edge: R[Dst] <= ALUOut (all 32 bits regardless of FunSel[4]); WF <= 0; Done <= 1; Skipped <= 0; go to IDLE.
  - The ALU updates its flags on the same edge when WF = 1.
- Latency and throughput:
  - ALU op: accept edge, then one ISSUE cycle; the result is visible in R and DbgData, with Done high, in the cycle after ISSUE.
  - A new instruction may be accepted in the Done cycle, giving 2 cycles per ALU op and 1 cycle per immediate load.
- Done and Skipped are high for exactly one cycle per retired instruction and 0 otherwise.
- Src == Dst is legal: operands are captured before the write.
- DbgData is combinational and reflects a write in the cycle after the write edge.
- A and B hold their last values in IDLE; FunSel holds its last value.

Test Plan:
- Reset mid-ISSUE (after accepting an op with Dst=3) → R3 unchanged (0), WF=0, InReady=1, Done=0 the next cycle.
- LoadImm R1=5, LoadImm R2=7, then op FunSel=10100 (add), Src 1,2, Dst 3, S=1 → A=5, B=7, WF=1 for exactly the ISSUE cycle; Done one cycle later; DbgData(3)=12; ALU Z=0.
- R1=0xFFFFFFFF, R2=1, add with S=1 → R4=0, Z=1, C=1. Next, op with Cond=01 → executes. Op with Cond=10 → Done=1, Skipped=1, destination unchanged, WF never asserted.
- InValid held high during ISSUE → InReady=0, second instruction not accepted until the Done cycle, then accepted immediately (2-cycle spacing).
- Src=Dst=1, R1=3, FunSel=11011 (LSL) → R1=6; back-to-back repeat → R1=12.

Source files
------------

// File: rtl/alu_issue_writeback_if.sv
// Instruction handshake, ALU operand/result and debug-read signals of the issue/writeback stage.
interface alu_issue_writeback_if #(
  parameter int DW = 32
);
  logic          InValid;
  logic          InReady;
  logic [4:0]    InFunSel;
  logic [2:0]    InSrcA;
  logic [2:0]    InSrcB;
  logic [2:0]    InDst;
  logic          InS;
  logic [1:0]    InCond;
  logic          InLoadImm;
  logic [DW-1:0] InImm;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [4:0]    FunSel;
  logic          WF;
  logic [DW-1:0] ALUOut;
  logic [3:0]    FlagsIn;
  logic          Done;
  logic          Skipped;
  logic [2:0]    DbgSel;
  logic [DW-1:0] DbgData;

  modport master (
    output InValid, InFunSel, InSrcA, InSrcB, InDst, InS, InCond, InLoadImm, InImm,
    output ALUOut, FlagsIn, DbgSel,
    input  InReady, A, B, FunSel, WF, Done, Skipped, DbgData
  );

  modport slave (
    input  InValid, InFunSel, InSrcA, InSrcB, InDst, InS, InCond, InLoadImm, InImm,
    input  ALUOut, FlagsIn, DbgSel,
    output InReady, A, B, FunSel, WF, Done, Skipped, DbgData
  );
endinterface

// File: rtl/alu_issue_writeback.sv
// Operand-issue / result-writeback stage around the ALU with an 8 x 32-bit register file
// and conditional execution on the ALU flags {Z,C,N,O}.
module alu_issue_writeback #(
  parameter int NREG = 8,
  parameter int DW   = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  alu_issue_writeback_if.slave  bus
);
  typedef enum logic {IDLE, ISSUE} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [4:0]    fun_sel_q, fun_sel_d;
  logic          wf_q, wf_d;
  logic          done_q, done_d;
  logic          skipped_q, skipped_d;
  logic [2:0]    dst_q, dst_d;
  logic          accept;
  logic          cond_ok;

  assign accept = bus.InValid && (state_q == IDLE);

  // Flags are stable at the accept edge because WF is never high in IDLE.
  always_comb begin
    cond_ok = 1'b0;
    unique case (bus.InCond)
      2'b00: cond_ok = 1'b1;
      2'b01: cond_ok = bus.FlagsIn[3];
      2'b10: cond_ok = !bus.FlagsIn[3];
      2'b11: cond_ok = bus.FlagsIn[2];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    regs_d    = regs_q;
    a_d       = a_q;
    b_d       = b_q;
    fun_sel_d = fun_sel_q;
    wf_d      = wf_q;
    dst_d     = dst_q;
    done_d    = 1'b0;
    skipped_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.InLoadImm) begin
            if (cond_ok) regs_d[bus.InDst] = bus.InImm;
            done_d    = 1'b1;
            skipped_d = !cond_ok;
          end else if (cond_ok) begin
            a_d       = regs_q[bus.InSrcA];
            b_d       = regs_q[bus.InSrcB];
            fun_sel_d = bus.InFunSel;
            wf_d      = bus.InS;
            dst_d     = bus.InDst;
            state_d   = ISSUE;
          end else begin
            wf_d      = 1'b0;
            done_d    = 1'b1;
            skipped_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        regs_d[dst_q] = bus.ALUOut;
        wf_d          = 1'b0;
        done_d        = 1'b1;
        skipped_d     = 1'b0;
        state_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      a_q       <= '0;
      b_q       <= '0;
      fun_sel_q <= '0;
      wf_q      <= 1'b0;
      dst_q     <= '0;
      done_q    <= 1'b0;
      skipped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      regs_q    <= regs_d;
      a_q       <= a_d;
      b_q       <= b_d;
      fun_sel_q <= fun_sel_d;
      wf_q      <= wf_d;
      dst_q     <= dst_d;
      done_q    <= done_d;
      skipped_q <= skipped_d;
    end
  end

  assign bus.InReady = (state_q == IDLE);
  assign bus.A       = a_q;
  assign bus.B       = b_q;
  assign bus.FunSel  = fun_sel_q;
  assign bus.WF      = wf_q;
  assign bus.Done    = done_q;
  assign bus.Skipped = skipped_q;
  assign bus.DbgData = regs_q[bus.DbgSel];
endmodule

// File: tb/tb_alu_issue_writeback.sv
// Bench for alu_issue_writeback: behavioural ALU on the bus plus an array/flag reference model.
module tb_alu_issue_writeback;
  logic Clock;
  logic Reset;
  int unsigned checks;
  int unsigned failures;
  int unsigned last_wait;

  logic [31:0] ref_regs [8];
  logic [3:0]  ref_flags;
  logic [3:0]  alu_flags;
  logic [35:0] alu_full;

  alu_issue_writeback_if bus ();

  alu_issue_writeback dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Returns {Z,C,N,O,result}
  function automatic logic [35:0] alu_ref(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] res;
    logic c, o;
    c = 1'b0; o = 1'b0; w = '0;
    case (fs)
      5'b10100: begin w = {1'b0, a} + {1'b0, b}; res = w[31:0]; c = w[32];
                      o = (a[31] == b[31]) && (res[31] != a[31]); end
      5'b10101: begin w = {1'b0, a} - {1'b0, b}; res = w[31:0]; c = !w[32];
                      o = (a[31] != b[31]) && (res[31] != a[31]); end
      5'b11000: res = a & b;
      5'b11001: res = a | b;
      5'b11010: res = a ^ b;
      5'b11011: begin res = a << 1; c = a[31]; end
      default:  res = a;
    endcase
    return {(res == 32'd0), c, res[31], o, res};
  endfunction

  function automatic logic [4:0] pick_fs(input int unsigned k);
    case (k)
      0: return 5'b10100;
      1: return 5'b10101;
      2: return 5'b11000;
      3: return 5'b11001;
      4: return 5'b11010;
      default: return 5'b11011;
    endcase
  endfunction

  function automatic bit cond_true(input logic [3:0] f, input logic [1:0] c);
    case (c)
      2'd0: return 1'b1;
      2'd1: return f[3];
      2'd2: return !f[3];
      default: return f[2];
    endcase
  endfunction

  assign alu_full    = alu_ref(bus.FunSel, bus.A, bus.B);
  assign bus.ALUOut  = alu_full[31:0];
  assign bus.FlagsIn = alu_flags;

  always @(posedge Clock) begin
    if (Reset) alu_flags <= '0;
    else if (bus.WF) alu_flags <= alu_full[35:32];
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    ref_flags = '0;
  endtask

  task automatic send(input bit ld, input logic [4:0] fs, input logic [2:0] sa, input logic [2:0] sb,
                      input logic [2:0] d, input bit s, input logic [1:0] cond, input logic [31:0] imm);
    bit cok;
    logic [35:0] r;
    bus.InValid = 1'b1; bus.InLoadImm = ld; bus.InFunSel = fs; bus.InSrcA = sa; bus.InSrcB = sb;
    bus.InDst = d; bus.InS = s; bus.InCond = cond; bus.InImm = imm;
    last_wait = 0;
    while (bus.InReady !== 1'b1 && last_wait < 10) begin @(posedge Clock); #1; last_wait++; end
    if (bus.InReady !== 1'b1) begin
      checks++; failures++;
      $display("FAIL accept_timeout got InReady=%b exp=1", bus.InReady);
      bus.InValid = 1'b0;
      return;
    end
    cok = cond_true(ref_flags, cond);
    r = alu_ref(fs, ref_regs[sa], ref_regs[sb]);
    @(posedge Clock); #1;
    bus.InValid = 1'b0;
    if (ld || !cok) begin
      if (ld && cok) ref_regs[d] = imm;
      checks++; if (bus.Done !== 1'b1) begin failures++; $display("FAIL done_short got=%b exp=1", bus.Done); end
      checks++; if (bus.Skipped !== !cok) begin failures++; $display("FAIL skipped got=%b exp=%b", bus.Skipped, !cok); end
      checks++; if (bus.WF !== 1'b0) begin failures++; $display("FAIL wf_short got=%b exp=0", bus.WF); end
      checks++; if (bus.InReady !== 1'b1) begin failures++; $display("FAIL ready_short got=%b exp=1", bus.InReady); end
    end else begin
      checks++; if (bus.A !== ref_regs[sa]) begin failures++; $display("FAIL opA got=%h exp=%h", bus.A, ref_regs[sa]); end
      checks++; if (bus.B !== ref_regs[sb]) begin failures++; $display("FAIL opB got=%h exp=%h", bus.B, ref_regs[sb]); end
      checks++; if (bus.FunSel !== fs) begin failures++; $display("FAIL funsel got=%b exp=%b", bus.FunSel, fs); end
      checks++; if (bus.WF !== s) begin failures++; $display("FAIL wf_issue got=%b exp=%b", bus.WF, s); end
      checks++; if (bus.Done !== 1'b0 || bus.InReady !== 1'b0) begin failures++;
        $display("FAIL issue_state got done=%b ready=%b exp done=0 ready=0", bus.Done, bus.InReady); end
      @(posedge Clock); #1;
      ref_regs[d] = r[31:0];
      if (s) ref_flags = r[35:32];
      checks++; if (bus.Done !== 1'b1 || bus.Skipped !== 1'b0) begin failures++;
        $display("FAIL done_op got done=%b skipped=%b exp done=1 skipped=0", bus.Done, bus.Skipped); end
      checks++; if (bus.WF !== 1'b0) begin failures++; $display("FAIL wf_after got=%b exp=0", bus.WF); end
    end
    bus.DbgSel = d; #1;
    checks++; if (bus.DbgData !== ref_regs[d]) begin failures++;
      $display("FAIL dst_value r%0d got=%h exp=%h", d, bus.DbgData, ref_regs[d]); end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    model_reset();
    checks++; if (bus.A !== '0 || bus.B !== '0 || bus.FunSel !== '0) begin failures++;
      $display("FAIL reset_ops got A=%h B=%h F=%b exp 0", bus.A, bus.B, bus.FunSel); end
    checks++; if (bus.WF !== 1'b0 || bus.Done !== 1'b0 || bus.Skipped !== 1'b0 || bus.InReady !== 1'b1) begin failures++;
      $display("FAIL reset_ctl got wf=%b done=%b sk=%b rdy=%b exp 0 0 0 1", bus.WF, bus.Done, bus.Skipped, bus.InReady); end
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.DbgSel = 3'(i); #1;
      checks++; if (bus.DbgData !== 32'd0) begin failures++; $display("FAIL reset_reg r%0d got=%h exp=0", i, bus.DbgData); end
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_add();
    send(1, 5'b0, 0, 0, 1, 0, 2'b00, 32'd5);
    send(1, 5'b0, 0, 0, 2, 0, 2'b00, 32'd7);
    send(0, 5'b10100, 1, 2, 3, 1, 2'b00, 32'd0);
    bus.DbgSel = 3; #1;
    checks++; if (bus.DbgData !== 32'd12) begin failures++; $display("FAIL add_r3 got=%h exp=c", bus.DbgData); end
    checks++; if (bus.FlagsIn[3] !== 1'b0) begin failures++; $display("FAIL add_z got=%b exp=0", bus.FlagsIn[3]); end
    @(posedge Clock); #1;
    checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL done_pulse got=%b exp=0", bus.Done); end
  endtask

  task automatic test_cond();
    send(1, 5'b0, 0, 0, 1, 0, 2'b00, 32'hFFFF_FFFF);
    send(1, 5'b0, 0, 0, 2, 0, 2'b00, 32'd1);
    send(0, 5'b10100, 1, 2, 4, 1, 2'b00, 32'd0);
    checks++; if (bus.FlagsIn[3:2] !== 2'b11) begin failures++; $display("FAIL wrap_zc got=%b exp=11", bus.FlagsIn[3:2]); end
    bus.DbgSel = 4; #1;
    checks++; if (bus.DbgData !== 32'd0) begin failures++; $display("FAIL wrap_r4 got=%h exp=0", bus.DbgData); end
    send(0, 5'b10100, 2, 2, 5, 0, 2'b01, 32'd0);
    send(0, 5'b10100, 2, 2, 6, 1, 2'b10, 32'd0);
    send(1, 5'b0, 0, 0, 6, 0, 2'b10, 32'hDEAD_BEEF);
    send(0, 5'b11001, 1, 2, 7, 0, 2'b11, 32'd0);
    checks++; if (bus.FlagsIn !== ref_flags) begin failures++; $display("FAIL cond_flags got=%b exp=%b", bus.FlagsIn, ref_flags); end
  endtask

  task automatic test_hold();
    logic [35:0] r1, r2;
    logic [31:0] a1;
    bus.InValid = 1'b1; bus.InLoadImm = 0; bus.InFunSel = 5'b10100; bus.InSrcA = 1; bus.InSrcB = 2;
    bus.InDst = 3; bus.InS = 0; bus.InCond = 2'b00; bus.InImm = '0;
    a1 = ref_regs[1];
    r1 = alu_ref(5'b10100, ref_regs[1], ref_regs[2]);
    @(posedge Clock); #1;
    bus.InFunSel = 5'b10101; bus.InSrcA = 3; bus.InSrcB = 1; bus.InDst = 7;
    checks++; if (bus.InReady !== 1'b0) begin failures++; $display("FAIL hold_ready got=%b exp=0", bus.InReady); end
    @(posedge Clock); #1;
    ref_regs[3] = r1[31:0];
    checks++; if (bus.Done !== 1'b1 || bus.InReady !== 1'b1) begin failures++;
      $display("FAIL hold_done got done=%b rdy=%b exp 1 1", bus.Done, bus.InReady); end
    checks++; if (bus.A !== a1 || bus.WF !== 1'b0) begin failures++; $display("FAIL hold_noaccept got A=%h wf=%b exp A=%h wf=0", bus.A, bus.WF, a1); end
    r2 = alu_ref(5'b10101, ref_regs[3], ref_regs[1]);
    @(posedge Clock); #1;
    bus.InValid = 1'b0;
    checks++; if (bus.A !== ref_regs[3] || bus.B !== ref_regs[1]) begin failures++;
      $display("FAIL hold_second got A=%h B=%h exp A=%h B=%h", bus.A, bus.B, ref_regs[3], ref_regs[1]); end
    checks++; if (bus.InReady !== 1'b0 || bus.Done !== 1'b0) begin failures++;
      $display("FAIL hold_issue2 got rdy=%b done=%b exp 0 0", bus.InReady, bus.Done); end
    @(posedge Clock); #1;
    ref_regs[7] = r2[31:0];
    bus.DbgSel = 7; #1;
    checks++; if (bus.DbgData !== ref_regs[7] || bus.Done !== 1'b1) begin failures++;
      $display("FAIL hold_r7 got=%h done=%b exp=%h done=1", bus.DbgData, bus.Done, ref_regs[7]); end
  endtask

  task automatic test_back_to_back();
    send(1, 5'b0, 0, 0, 1, 0, 2'b00, 32'd3);
    send(0, 5'b11011, 1, 1, 1, 0, 2'b00, 32'd0);
    send(0, 5'b11011, 1, 1, 1, 0, 2'b00, 32'd0);
    checks++; if (last_wait != 0) begin failures++; $display("FAIL b2b_wait got=%0d exp=0", last_wait); end
    bus.DbgSel = 1; #1;
    checks++; if (bus.DbgData !== 32'd12) begin failures++; $display("FAIL lsl_r1 got=%h exp=c", bus.DbgData); end
  endtask

  task automatic test_reset_mid_issue();
    Reset = 1'b1; @(posedge Clock); #1; Reset = 1'b0;
    model_reset();
    send(1, 5'b0, 0, 0, 1, 0, 2'b00, 32'd9);
    send(1, 5'b0, 0, 0, 2, 0, 2'b00, 32'd4);
    bus.InValid = 1'b1; bus.InLoadImm = 0; bus.InFunSel = 5'b10100; bus.InSrcA = 1; bus.InSrcB = 2;
    bus.InDst = 3; bus.InS = 1; bus.InCond = 2'b00;
    @(posedge Clock); #1;
    bus.InValid = 1'b0;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    model_reset();
    bus.DbgSel = 3; #1;
    checks++; if (bus.DbgData !== 32'd0) begin failures++; $display("FAIL rst_mid_r3 got=%h exp=0", bus.DbgData); end
    checks++; if (bus.WF !== 1'b0 || bus.InReady !== 1'b1 || bus.Done !== 1'b0) begin failures++;
      $display("FAIL rst_mid_ctl got wf=%b rdy=%b done=%b exp 0 1 0", bus.WF, bus.InReady, bus.Done); end
    @(posedge Clock); #1;
    checks++; if (bus.Done !== 1'b0 || bus.FlagsIn !== 4'd0) begin failures++;
      $display("FAIL rst_mid_next got done=%b flags=%b exp 0 0000", bus.Done, bus.FlagsIn); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 3)
        send(1, 5'b0, 0, 0, 3'($urandom_range(0, 7)), 0, 2'($urandom_range(0, 3)), $urandom);
      else
        send(0, pick_fs($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'd0);
      checks++; if (bus.FlagsIn !== ref_flags) begin failures++; $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, bus.FlagsIn, ref_flags); end
      if ($urandom_range(0, 3) == 0) begin @(posedge Clock); #1; end
    end
    for (int i = 0; i < 8; i++) begin
      bus.DbgSel = 3'(i); #1;
      checks++; if (bus.DbgData !== ref_regs[i]) begin failures++; $display("FAIL rnd_reg r%0d got=%h exp=%h", i, bus.DbgData, ref_regs[i]); end
    end
  endtask

  initial begin
    checks = 0; failures = 0; last_wait = 0;
    Reset = 1'b1;
    bus.InValid = 1'b0; bus.InLoadImm = 1'b0; bus.InFunSel = '0; bus.InSrcA = '0; bus.InSrcB = '0;
    bus.InDst = '0; bus.InS = 1'b0; bus.InCond = '0; bus.InImm = '0; bus.DbgSel = '0;
    model_reset();
    test_reset();
    test_add();
    test_cond();
    test_hold();
    test_back_to_back();
    test_reset_mid_issue();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
